br_resolve: RTL

- Branch resolution stage downstream of the branch comparator in EX of the 5-stage RV32I pipeline.
- Consumes the comparator's less/equal flags and decodes funct3 into the comparator's unsigned-mode select.
- Decides the actual branch/jump outcome and checks it against the IF prediction. On mispredict it issues a registered redirect and flush to fetch/pipeline control.
- Owns the 2-bit BHT used by IF for direction prediction and keeps branch/mispredict statistics counters.

---
 rtl/br_resolve.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/br_resolve.sv
// Branch resolution for the EX stage: decides the real outcome, checks it against
// the IF prediction, issues a one-cycle redirect/flush, and owns the 2-bit BHT.
module br_resolve #(
  parameter int BHT_ENTRIES = 64,
  parameter int PC_W        = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_valid,
  input  logic            i_ex_stall,
  input  logic            i_ex_is_br,
  input  logic            i_ex_is_jmp,
  input  logic [2:0]      i_ex_funct3,
  input  logic [PC_W-1:0] i_ex_pc,
  input  logic [PC_W-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [PC_W-1:0] i_ex_pred_target,
  input  logic            i_br_less,
  input  logic            i_br_equal,
  output logic            o_br_un,
  input  logic [PC_W-1:0] i_if_pc,
  output logic            o_if_pred_taken,
  output logic            o_redirect_valid,
  output logic [PC_W-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic [31:0]     o_stat_br_cnt,
  output logic [31:0]     o_stat_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t          r_state;
  logic            r_redirect_valid;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_flush;
  logic [31:0]     r_br_cnt;
  logic [31:0]     r_mispred_cnt;
  logic [1:0]      r_bht [BHT_ENTRIES];

  logic             w_f3_legal;
  logic             w_br_taken;
  logic             w_taken;
  logic             w_legal;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_bht_we;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [1:0]       w_bht_old;
  logic [1:0]       w_bht_next;
  logic             w_unused_bits;

  assign w_unused_bits = ^{i_if_pc[PC_W-1:IDX_W+2], i_if_pc[1:0]};

  assign o_br_un  = i_ex_funct3[1];
  assign w_rd_idx = i_if_pc[IDX_W+1:2];
  assign w_wr_idx = i_ex_pc[IDX_W+1:2];
  assign o_if_pred_taken = r_bht[w_rd_idx][1];

  // funct3 010/011 are not branches; they are neither taken nor resolved
  always_comb begin
    w_f3_legal = 1'b1;
    w_br_taken = 1'b0;
    case (i_ex_funct3)
      3'b000:          w_br_taken = i_br_equal;
      3'b001:          w_br_taken = ~i_br_equal;
      3'b100, 3'b110:  w_br_taken = i_br_less;
      3'b101, 3'b111:  w_br_taken = ~i_br_less;
      default:         w_f3_legal = 1'b0;
    endcase
  end

  assign w_taken      = i_ex_is_jmp | w_br_taken;
  assign w_legal      = i_ex_is_jmp | (i_ex_is_br & w_f3_legal);
  assign w_resolve    = i_ex_valid & ~i_ex_stall & w_legal & (r_state == RUN);
  assign w_mispredict = w_resolve &
                        ((w_taken != i_ex_pred_taken) |
                         (w_taken & (i_ex_target != i_ex_pred_target)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= RUN;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mispredict) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_taken ? i_ex_target : (i_ex_pc + PC_W'(4));
            r_flush          <= 1'b1;
            r_state          <= SQUASH;
          end else begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
          end
        end
        // Wrong-path EX contents sit here for one cycle and are dropped
        SQUASH: begin
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_state          <= RUN;
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_state          <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve)    r_br_cnt      <= r_br_cnt + 32'd1;
      if (w_mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  // Jumps are always taken, so they never train the direction table
  assign w_bht_we  = w_resolve & i_ex_is_br & ~i_ex_is_jmp;
  assign w_bht_old = r_bht[w_wr_idx];

  always_comb begin
    w_bht_next = w_bht_old;
    if (w_br_taken) begin
      if (w_bht_old != 2'b11) w_bht_next = w_bht_old + 2'b01;
    end else begin
      if (w_bht_old != 2'b00) w_bht_next = w_bht_old - 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (w_bht_we) begin
      r_bht[w_wr_idx] <= w_bht_next;
    end
  end

  assign o_redirect_valid   = r_redirect_valid;
  assign o_redirect_pc      = r_redirect_pc;
  assign o_flush            = r_flush;
  assign o_stat_br_cnt      = r_br_cnt;
  assign o_stat_mispred_cnt = r_mispred_cnt;

endmodule
